// File: rtl/led7_mux.sv
`default_nettype none
// ============================================================================
// Module   : led7_mux
// Purpose  : Time-multiplexed driver for a bank of common-anode 7-segment
//            digits. A prescaler sets the dwell time of each digit slot; a
//            new value is staged in a pending set and only copied to the
//            displayed set at a frame wrap, so a frame never shows a mix of
//            old and new digits.
// Ports    : i_w_clk    - clock, all state updates on its rising edge
//            i_w_reset  - synchronous active-high reset
//            i_w_data   - 4*DIGITS hex nibbles, nibble k -> digit k (0 = right)
//            i_w_en     - per-digit enable, 0 blanks the digit
//            i_w_dp     - per-digit decimal point, 1 lights it
//            i_w_lzs    - leading-zero suppression enable
//            i_w_load   - capture data/en/dp when high
//            o_w_7seg   - active-low segments, bit0 = a .. bit6 = g
//            o_w_dp     - active-low decimal point
//            o_w_an     - active-low one-hot anodes
//            o_w_frame  - one-cycle pulse in the first cycle of each frame
// Revision : 1.0 - initial release
// ============================================================================
module led7_mux #(
  parameter int DIGITS   = 8,
  parameter int PRESCALE = 1000
) (
  input  logic                  i_w_clk,
  input  logic                  i_w_reset,
  input  logic [4*DIGITS-1:0]   i_w_data,
  input  logic [DIGITS-1:0]     i_w_en,
  input  logic [DIGITS-1:0]     i_w_dp,
  input  logic                  i_w_lzs,
  input  logic                  i_w_load,
  output logic [6:0]            o_w_7seg,
  output logic                  o_w_dp,
  output logic [DIGITS-1:0]     o_w_an,
  output logic                  o_w_frame
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0]     PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] AN_ONE   = DIGITS'(1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [PW-1:0]       presc_q,     presc_d;
  logic [IW-1:0]       idx_q,       idx_d;
  logic [4*DIGITS-1:0] pend_data_q, pend_data_d;
  logic [DIGITS-1:0]   pend_en_q,   pend_en_d;
  logic [DIGITS-1:0]   pend_dp_q,   pend_dp_d;
  logic                pend_vld_q,  pend_vld_d;
  logic [4*DIGITS-1:0] disp_data_q, disp_data_d;
  logic [DIGITS-1:0]   disp_en_q,   disp_en_d;
  logic [DIGITS-1:0]   disp_dp_q,   disp_dp_d;
  logic                frame_q,     frame_d;

  logic w_tick;
  logic w_wrap;

  assign w_tick = (presc_q == PRE_LAST);
  assign w_wrap = w_tick && (idx_q == IDX_LAST);

  always_comb begin
    presc_d     = w_tick ? '0 : presc_q + 1'b1;
    idx_d       = idx_q;
    pend_data_d = pend_data_q;
    pend_en_d   = pend_en_q;
    pend_dp_d   = pend_dp_q;
    pend_vld_d  = pend_vld_q;
    disp_data_d = disp_data_q;
    disp_en_d   = disp_en_q;
    disp_dp_d   = disp_dp_q;
    frame_d     = w_wrap;

    if (w_tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    if (w_wrap) begin
      // A load on the wrap edge bypasses the pending set and wins over it.
      if (i_w_load) begin
        disp_data_d = i_w_data;
        disp_en_d   = i_w_en;
        disp_dp_d   = i_w_dp;
        pend_vld_d  = 1'b0;
      end else if (pend_vld_q) begin
        disp_data_d = pend_data_q;
        disp_en_d   = pend_en_q;
        disp_dp_d   = pend_dp_q;
        pend_vld_d  = 1'b0;
      end
    end else if (i_w_load) begin
      pend_data_d = i_w_data;
      pend_en_d   = i_w_en;
      pend_dp_d   = i_w_dp;
      pend_vld_d  = 1'b1;
    end
  end

  always_ff @(posedge i_w_clk) begin
    if (i_w_reset) begin
      presc_q     <= '0;
      idx_q       <= '0;
      pend_data_q <= '0;
      pend_en_q   <= '0;
      pend_dp_q   <= '0;
      pend_vld_q  <= 1'b0;
      disp_data_q <= '0;
      disp_en_q   <= '0;
      disp_dp_q   <= '0;
      frame_q     <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      pend_data_q <= pend_data_d;
      pend_en_q   <= pend_en_d;
      pend_dp_q   <= pend_dp_d;
      pend_vld_q  <= pend_vld_d;
      disp_data_q <= disp_data_d;
      disp_en_q   <= disp_en_d;
      disp_dp_q   <= disp_dp_d;
      frame_q     <= frame_d;
    end
  end

  // --------------------------------------------------------------------------
  // Output decode
  // --------------------------------------------------------------------------
  // w_tail_zero[k] is set when nibbles k..DIGITS-1 of the displayed value are
  // all zero, i.e. digit k is a leading zero.
  logic [DIGITS-1:0] w_tail_zero;

  always_comb begin
    logic run_zero;
    run_zero    = 1'b1;
    w_tail_zero = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      run_zero       = run_zero & (disp_data_q[4*k +: 4] == 4'h0);
      w_tail_zero[k] = run_zero;
    end
  end

  logic [3:0] w_nib;
  logic       w_suppress;
  logic       w_visible;
  logic [6:0] w_seg;

  assign w_nib      = disp_data_q[{idx_q, 2'b00} +: 4];
  assign w_suppress = i_w_lzs && (idx_q != '0) && w_tail_zero[idx_q];
  assign w_visible  = disp_en_q[idx_q] && !w_suppress;

  always_comb begin
    w_seg = 7'h7F;
    case (w_nib)
      4'h0: w_seg = 7'h40;
      4'h1: w_seg = 7'h79;
      4'h2: w_seg = 7'h24;
      4'h3: w_seg = 7'h30;
      4'h4: w_seg = 7'h19;
      4'h5: w_seg = 7'h12;
      4'h6: w_seg = 7'h02;
      4'h7: w_seg = 7'h78;
      4'h8: w_seg = 7'h00;
      4'h9: w_seg = 7'h10;
      4'hA: w_seg = 7'h08;
      4'hB: w_seg = 7'h03;
      4'hC: w_seg = 7'h46;
      4'hD: w_seg = 7'h21;
      4'hE: w_seg = 7'h06;
      4'hF: w_seg = 7'h0E;
      default: w_seg = 7'h7F;
    endcase
  end

  always_comb begin
    o_w_an   = '1;
    o_w_7seg = 7'h7F;
    o_w_dp   = 1'b1;
    if (w_visible) begin
      o_w_an   = ~(AN_ONE << idx_q);
      o_w_7seg = w_seg;
      o_w_dp   = ~disp_dp_q[idx_q];
    end
  end

  assign o_w_frame = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_led7_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_led7_mux
// Purpose  : Self-checking bench for led7_mux (DIGITS=4, PRESCALE=2). The
//            stimulus process queues the hand-computed outputs expected in
//            each cycle; a monitor on the falling edge pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led7_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data;
  logic [3:0]  en;
  logic [3:0]  dpin;
  logic        lzs;
  logic        load;
  logic [6:0]  seg;
  logic        dpo;
  logic [3:0]  an;
  logic        frame;

  always #5 clk = ~clk;

  led7_mux #(.DIGITS(4), .PRESCALE(2)) u_dut (
    .i_w_clk   (clk),
    .i_w_reset (rst),
    .i_w_data  (data),
    .i_w_en    (en),
    .i_w_dp    (dpin),
    .i_w_lzs   (lzs),
    .i_w_load  (load),
    .o_w_7seg  (seg),
    .o_w_dp    (dpo),
    .o_w_an    (an),
    .o_w_frame (frame)
  );

  typedef struct {
    string       scen;
    int          cyc;
    logic [12:0] v;     // {an, seg, dp, frame}
  } exp_t;

  exp_t  sb[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  string scen     = "init";
  int    cyc_no   = 0;

  // Monitor: one expected entry per cycle, compared mid-cycle.
  always @(negedge clk) begin : mon
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_checks++;
      if ({an, seg, dpo, frame} !== e.v) begin
        n_fail++;
        $display("FAIL %s cycle=%0d got an=%h seg=%h dp=%b frame=%b required an=%h seg=%h dp=%b frame=%b",
                 e.scen, e.cyc, an, seg, dpo, frame,
                 e.v[12:9], e.v[8:2], e.v[1], e.v[0]);
      end
    end
  end

  // Queue the expectation for the current cycle, then advance one cycle.
  task automatic cyc(input logic [3:0] e_an, input logic [6:0] e_seg,
                     input logic e_dp, input logic e_fr);
    exp_t e;
    e.scen = scen;
    e.cyc  = cyc_no;
    e.v    = {e_an, e_seg, e_dp, e_fr};
    sb.push_back(e);
    @(posedge clk);
    #1;
    load   = 1'b0;
    cyc_no = cyc_no + 1;
  endtask

  task automatic blank(input int n);
    repeat (n) cyc(4'hF, 7'h7F, 1'b1, 1'b0);
  endtask

  // One digit slot lasts two cycles; the frame pulse can only be in the first.
  task automatic show2(input logic [3:0] e_an, input logic [6:0] e_seg,
                       input logic e_dp, input logic e_fr);
    cyc(e_an, e_seg, e_dp, e_fr);
    cyc(e_an, e_seg, e_dp, 1'b0);
  endtask

  task automatic ld(input logic [15:0] d, input logic [3:0] e, input logic [3:0] p);
    load = 1'b1;
    data = d;
    en   = e;
    dpin = p;
  endtask

  // Two reset edges; returns at the start of cycle 0.
  task automatic do_reset(input string nm);
    scen = nm;
    rst  = 1'b1;
    load = 1'b0;
    lzs  = 1'b0;
    @(posedge clk);
    #1;
    cyc_no = -1;
    cyc(4'hF, 7'h7F, 1'b1, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst  = 1'b1;
    data = '0;
    en   = '0;
    dpin = '0;
    lzs  = 1'b0;
    load = 1'b0;
    @(posedge clk);
    #1;

    // Basic scan of 1234, then a mid-frame load held back until the wrap.
    do_reset("basic");
    ld(16'h1234, 4'hF, 4'h0);
    blank(1);                          // c0
    blank(7);                          // c1..c7
    show2(4'hE, 7'h19, 1'b1, 1'b1);    // c8  digit0 = 4
    ld(16'h5678, 4'hF, 4'h0);          // c10 load, must not tear this frame
    show2(4'hD, 7'h30, 1'b1, 1'b0);    // c10 digit1 = 3
    show2(4'hB, 7'h24, 1'b1, 1'b0);    // c12 digit2 = 2
    show2(4'h7, 7'h79, 1'b1, 1'b0);    // c14 digit3 = 1
    show2(4'hE, 7'h00, 1'b1, 1'b1);    // c16 digit0 = 8
    show2(4'hD, 7'h78, 1'b1, 1'b0);    // c18 digit1 = 7

    // Two loads in one frame: last one wins.
    do_reset("last_wins");
    blank(2);                          // c0..c1
    ld(16'h1111, 4'hF, 4'h0);
    blank(3);                          // c2..c4
    ld(16'h2222, 4'hF, 4'h0);
    blank(3);                          // c5..c7
    show2(4'hE, 7'h24, 1'b1, 1'b1);
    show2(4'hD, 7'h24, 1'b1, 1'b0);
    show2(4'hB, 7'h24, 1'b1, 1'b0);
    show2(4'h7, 7'h24, 1'b1, 1'b0);

    // Leading-zero suppression.
    do_reset("lzs");
    lzs = 1'b1;
    ld(16'h0050, 4'hF, 4'h0);
    blank(8);                          // c0..c7
    show2(4'hE, 7'h40, 1'b1, 1'b1);    // c8  digit0 = 0, never suppressed
    show2(4'hD, 7'h12, 1'b1, 1'b0);    // c10 digit1 = 5
    ld(16'h0000, 4'hF, 4'h0);
    show2(4'hF, 7'h7F, 1'b1, 1'b0);    // c12 digit2 suppressed
    show2(4'hF, 7'h7F, 1'b1, 1'b0);    // c14 digit3 suppressed
    show2(4'hE, 7'h40, 1'b1, 1'b1);    // c16 all zero, only digit0
    lzs = 1'b0;
    show2(4'hD, 7'h40, 1'b1, 1'b0);    // c18 suppression off -> digit1 shows 0

    // Per-digit enable and decimal point.
    do_reset("dp_en");
    ld(16'h8888, 4'hB, 4'h1);
    blank(8);
    show2(4'hE, 7'h00, 1'b0, 1'b1);    // digit0 dp lit
    show2(4'hD, 7'h00, 1'b1, 1'b0);
    show2(4'hF, 7'h7F, 1'b1, 1'b0);    // digit2 disabled
    show2(4'h7, 7'h00, 1'b1, 1'b0);

    // Load on the wrap edge, including priority over a pending load.
    do_reset("wrap_load");
    blank(7);                          // c0..c6
    ld(16'h1234, 4'hF, 4'h0);
    blank(1);                          // c7 = wrap edge
    show2(4'hE, 7'h19, 1'b1, 1'b1);    // c8
    show2(4'hD, 7'h30, 1'b1, 1'b0);    // c10
    ld(16'h9999, 4'hF, 4'h0);
    show2(4'hB, 7'h24, 1'b1, 1'b0);    // c12 (pending 9999)
    cyc(4'h7, 7'h79, 1'b1, 1'b0);      // c14
    ld(16'hABCD, 4'hF, 4'h0);
    cyc(4'h7, 7'h79, 1'b1, 1'b0);      // c15 = wrap edge
    show2(4'hE, 7'h21, 1'b1, 1'b1);    // c16 D
    show2(4'hD, 7'h46, 1'b1, 1'b0);    // C
    show2(4'hB, 7'h03, 1'b1, 1'b0);    // b
    show2(4'h7, 7'h08, 1'b1, 1'b0);    // A
    show2(4'hE, 7'h21, 1'b1, 1'b1);    // c24: pending 9999 was dropped

    // Mid-frame reset discards the pending load; reset beats a load.
    do_reset("reset_mid");
    ld(16'h1234, 4'hF, 4'h0);
    blank(5);                          // c0..c4
    rst = 1'b1;
    ld(16'h5555, 4'hF, 4'h1);
    blank(1);                          // c5, reset edge at its end
    rst    = 1'b0;
    cyc_no = 0;
    blank(8);                          // restarted c0..c7
    cyc(4'hF, 7'h7F, 1'b1, 1'b1);      // c8 frame pulse, nothing to show
    blank(7);
    cyc(4'hF, 7'h7F, 1'b1, 1'b1);      // c16

    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got %0d entries left required 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
